// File: rtl/requant_pipe.sv
// Pipelined per-channel requantiser: gain multiply, shift, round/truncate, saturate, pack.
// Optional build macro REQUANT_ROUND_EN selects round-half-to-even instead of floor truncation.
module requant_pipe #(
    parameter int IN_W       = 18,
    parameter int OUT_W      = 8,
    parameter int GAIN_W     = 11,
    parameter int N_CHAN     = 2048,
    parameter int BASE_SHIFT = 10,
    parameter int GAIN_LAT   = 1,
    parameter int ADDR_W     = $clog2(N_CHAN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic                arm,
    input  logic                sync_in,
    input  logic [2*IN_W-1:0]   requant_in,
    input  logic [3:0]          shift,
    output logic [ADDR_W-1:0]   addr,
    input  logic [GAIN_W-1:0]   gain,
    output logic [2*OUT_W-1:0]  requant_out,
    output logic                sync_out,
    output logic                overflow,
    output logic [15:0]         ovf_count
);

    localparam int PW = IN_W + GAIN_W + 1;
    localparam int SW = $clog2(PW + 1);
    localparam logic [ADDR_W-1:0] LAST_CHAN = ADDR_W'(N_CHAN - 1);
    localparam logic signed [PW-1:0] MAXV = PW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [PW-1:0] MINV = ~MAXV;

    generate
        if (BASE_SHIFT + 15 >= PW || BASE_SHIFT < 1 || GAIN_LAT < 1) begin : g_bad_cfg
            $error("requant_pipe: illegal BASE_SHIFT/GAIN_LAT for the product width");
        end
    endgenerate

    typedef enum logic [1:0] {
        WAIT_ARM  = 2'd0,
        WAIT_SYNC = 2'd1,
        RUNNING   = 2'd2
    } state_t;

    state_t              state, state_next;
    logic                sync_accept, enter_wait;
    logic [ADDR_W-1:0]   chan_count;
    logic [3:0]          shift_q;

    logic [2*IN_W-1:0]   a_data [GAIN_LAT];
    logic [GAIN_LAT-1:0] a_valid, a_first;
    logic [2*IN_W-1:0]   a_tail;
    logic signed [PW-1:0] re_ext, im_ext, gain_ext;

    logic                m_valid, m_first;
    logic signed [PW-1:0] m_re, m_im;
    logic [SW-1:0]       s_total;
    logic [OUT_W:0]      re_res, im_res;

    // Shift, round and clamp one product; result is {saturated, value}.
    function automatic logic [OUT_W:0] quant(input logic signed [PW-1:0] p,
                                             input logic [SW-1:0] s);
        logic signed [PW-1:0] q;
`ifdef REQUANT_ROUND_EN
        logic [PW-1:0] mask, rem, half;
`endif
        q = p >>> s;
`ifdef REQUANT_ROUND_EN
        mask = (PW'(1) << s) - PW'(1);
        rem  = p & mask;
        half = PW'(1) << (s - SW'(1));
        if (rem > half || (rem == half && q[0]))
            q = q + $signed(PW'(1));
`endif
        if (q > MAXV)
            return {1'b1, MAXV[OUT_W-1:0]};
        else if (q < MINV)
            return {1'b1, MINV[OUT_W-1:0]};
        else
            return {1'b0, q[OUT_W-1:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state <= WAIT_ARM;
        else if (ce)
            state <= state_next;
    end

    // Sync beats arm while waiting for sync; arm restarts alignment from RUNNING.
    always_comb begin
        state_next  = state;
        sync_accept = 1'b0;
        enter_wait  = 1'b0;
        case (state)
            WAIT_ARM: if (arm) begin
                state_next = WAIT_SYNC;
                enter_wait = 1'b1;
            end
            WAIT_SYNC: if (sync_in) begin
                state_next  = RUNNING;
                sync_accept = 1'b1;
            end
            RUNNING: if (arm) begin
                state_next = WAIT_SYNC;
                enter_wait = 1'b1;
            end
            default: state_next = WAIT_ARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chan_count <= '0;
            shift_q    <= '0;
        end else if (ce) begin
            if (sync_accept) begin
                chan_count <= '0;
                shift_q    <= shift;
            end else if (state == RUNNING) begin
                chan_count <= (chan_count == LAST_CHAN) ? '0 : chan_count + 1'b1;
            end
        end
    end

    assign addr = chan_count;

    // Delay line that lines each sample up with its gain RAM read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid <= '0;
            a_first <= '0;
        end else if (ce) begin
            a_valid[0] <= (state == RUNNING);
            a_first[0] <= (chan_count == '0);
            a_data[0]  <= requant_in;
            for (int i = 1; i < GAIN_LAT; i++) begin
                a_valid[i] <= a_valid[i-1];
                a_first[i] <= a_first[i-1];
                a_data[i]  <= a_data[i-1];
            end
        end
    end

    always_comb begin
        a_tail   = a_data[GAIN_LAT-1];
        re_ext   = PW'($signed(a_tail[2*IN_W-1:IN_W]));
        im_ext   = PW'($signed(a_tail[IN_W-1:0]));
        gain_ext = PW'({1'b0, gain});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_first <= 1'b0;
        end else if (ce) begin
            m_valid <= a_valid[GAIN_LAT-1];
            m_first <= a_first[GAIN_LAT-1];
            m_re    <= re_ext * gain_ext;
            m_im    <= im_ext * gain_ext;
        end
    end

    always_comb begin
        s_total = SW'(BASE_SHIFT) + SW'(shift_q);
        re_res  = quant(m_re, s_total);
        im_res  = quant(m_im, s_total);
    end

    // Outputs hold between valid samples; flags only live for one valid sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            requant_out <= '0;
            sync_out    <= 1'b0;
            overflow    <= 1'b0;
            ovf_count   <= '0;
        end else if (ce) begin
            if (m_valid) begin
                requant_out <= {re_res[OUT_W-1:0], im_res[OUT_W-1:0]};
                sync_out    <= m_first;
                overflow    <= re_res[OUT_W] | im_res[OUT_W];
            end else begin
                sync_out <= 1'b0;
                overflow <= 1'b0;
            end
            if (enter_wait)
                ovf_count <= '0;
            else if (m_valid && (re_res[OUT_W] || im_res[OUT_W]) && ovf_count != 16'hFFFF)
                ovf_count <= ovf_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_requant_pipe.sv
// Directed bench for requant_pipe: vector table, wrap/sync alignment, stalls, saturation and reset.
// Expected values follow the REQUANT_ROUND_EN build selection.
module tb_requant_pipe;

    localparam int N_CHAN = 2048;

    logic        clk = 1'b0;
    logic        rst, ce, arm, sync_in;
    logic [35:0] requant_in;
    logic [3:0]  shift;
    logic [10:0] addr;
    logic [10:0] gain = '0;
    logic [15:0] requant_out;
    logic        sync_out, overflow;
    logic [15:0] ovf_count;

    logic [10:0] gain_mem [N_CHAN];
    int total = 0;
    int bad   = 0;

    typedef struct {
        int          re;
        int          im;
        int          g;
        logic [15:0] out;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] out;
        logic        ovf;
        int          age;
    } exp_t;

    vec_t vecs [9];
    exp_t exp_q [$];

    requant_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .arm         (arm),
        .sync_in     (sync_in),
        .requant_in  (requant_in),
        .shift       (shift),
        .addr        (addr),
        .gain        (gain),
        .requant_out (requant_out),
        .sync_out    (sync_out),
        .overflow    (overflow),
        .ovf_count   (ovf_count)
    );

    always #5 clk = ~clk;

    // Gain RAM with one ce-qualified cycle of read latency.
    always @(posedge clk) if (ce) gain <= gain_mem[addr];

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic a, input logic s, input logic [35:0] d);
        arm        = a;
        sync_in    = s;
        requant_in = d;
        @(negedge clk);
    endtask

    function automatic logic [35:0] pack(input int re, input int im);
        return {re[17:0], im[17:0]};
    endfunction

    function automatic logic [8:0] quant1(input longint p, input longint d);
        longint q, r;
        q = p / d;
        r = p - q * d;
        if (r < 0) begin
            q = q - 1;
            r = r + d;
        end
`ifdef REQUANT_ROUND_EN
        if (2 * r > d || (2 * r == d && q[0])) q = q + 1;
`endif
        if (q > 127)  return {1'b1, 8'h7F};
        if (q < -128) return {1'b1, 8'h80};
        return {1'b0, q[7:0]};
    endfunction

    function automatic logic [16:0] model(input int re, input int im, input int g, input int sh);
        longint d;
        logic [8:0] r8, i8;
        d  = longint'(1) << (10 + sh);
        r8 = quant1(longint'(re) * g, d);
        i8 = quant1(longint'(im) * g, d);
        return {r8[8] | i8[8], r8[7:0], i8[7:0]};
    endfunction

    initial begin
        int exp_cnt;
        int pulses, first_pulse, second_pulse;
        logic last_ce;
        logic [10:0] prev_addr;
        logic [16:0] m;
        logic [35:0] pend_in;
        logic [16:0] pend_exp;
        int re, im, waited;

        vecs[0] = '{1000, -1000, 64, 16'h3EC1, 1'b0};
        vecs[1] = '{131071, -131072, 2047, 16'h7F80, 1'b1};
        vecs[2] = '{0, 0, 5, 16'h0000, 1'b0};
        vecs[3] = '{2048, -2048, 1, 16'h02FE, 1'b0};
        vecs[4] = '{1536, 512, 1, 16'h0100, 1'b0};
        vecs[5] = '{130048, -131072, 1, 16'h7F80, 1'b0};
        vecs[6] = '{1024, -1025, 128, 16'h7F80, 1'b1};
        vecs[7] = '{130560, 0, 1, 16'h7F00, 1'b0};
        vecs[8] = '{-1, -512, 1, 16'hFFFF, 1'b0};
`ifdef REQUANT_ROUND_EN
        vecs[0].out = 16'h3EC2;
        vecs[4].out = 16'h0200;
        vecs[7].ovf = 1'b1;
        vecs[8].out = 16'h0000;
`endif

        rst = 1'b1; ce = 1'b1; arm = 1'b0; sync_in = 1'b0; requant_in = '0; shift = '0;
        for (int k = 0; k < N_CHAN; k++) gain_mem[k] = '0;
        for (int k = 0; k < 9; k++) gain_mem[k] = 11'(vecs[k].g);
        repeat (3) @(negedge clk);
        checkOutput("rst_addr", addr, 0);
        checkOutput("rst_out", requant_out, 0);
        checkOutput("rst_sync", sync_out, 0);
        checkOutput("rst_ovf", overflow, 0);
        checkOutput("rst_cnt", ovf_count, 0);
        rst = 1'b0;

        // Vector table at shift 0, ce always on.
        applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, '0);
        sync_in = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 9) begin
                checkOutput("vec_addr", addr, i);
                requant_in = pack(vecs[i].re, vecs[i].im);
            end else begin
                requant_in = '0;
            end
            if (i >= 3) begin
                exp_cnt += int'(vecs[i-3].ovf);
                checkOutput($sformatf("vec%0d_out", i - 3), requant_out, vecs[i-3].out);
                checkOutput($sformatf("vec%0d_ovf", i - 3), overflow, vecs[i-3].ovf);
                checkOutput($sformatf("vec%0d_sync", i - 3), sync_out, (i == 3));
                checkOutput($sformatf("vec%0d_cnt", i - 3), ovf_count, exp_cnt);
            end else begin
                checkOutput("pre_sync", sync_out, 0);
            end
            @(negedge clk);
        end

        // Re-arm clears the overflow counter, then wrap and sync-ignore behaviour.
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("arm_clr_cnt", ovf_count, 0);
        applyStimulus(1'b0, 1'b1, '0);
        sync_in = 1'b0;
        pulses = 0; first_pulse = -1; second_pulse = -1;
        for (int j = 0; j < 2056; j++) begin
            if (j == 2047) checkOutput("wrap_addr_last", addr, 2047);
            if (j == 2048) checkOutput("wrap_addr_zero", addr, 0);
            sync_in = (j == 100);
            if (sync_out) begin
                pulses++;
                if (pulses == 1) first_pulse = j;
                if (pulses == 2) second_pulse = j;
            end
            @(negedge clk);
        end
        sync_in = 1'b0;
        checkOutput("wrap_pulses", pulses, 2);
        checkOutput("wrap_first", first_pulse, 3);
        checkOutput("wrap_second", second_pulse, 2051);

        // Random ce stalls against a per-sample reference with shift 3.
        for (int k = 0; k < N_CHAN; k++) gain_mem[k] = 11'($urandom_range(0, 2047));
        shift = 4'd3;
        applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, '0);
        sync_in = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        last_ce = 1'b0;
        pend_exp = '0;
        prev_addr = addr;
        for (int c = 0; c < 420; c++) begin
            if (last_ce) begin
                foreach (exp_q[k]) exp_q[k].age++;
                exp_q.push_back('{pend_exp[15:0], pend_exp[16], 1});
                exp_cnt += int'(pend_exp[16]);
            end else if (c > 0) begin
                checkOutput("stall_addr", addr, prev_addr);
            end
            if (exp_q.size() > 0 && exp_q[0].age == 3) begin
                checkOutput("rand_out", requant_out, exp_q[0].out);
                checkOutput("rand_ovf", overflow, exp_q[0].ovf);
                void'(exp_q.pop_front());
            end
            if (c < 400) begin
                ce = ($urandom_range(0, 99) >= 30);
                re = int'($urandom_range(0, 262143)) - 131072;
                im = int'($urandom_range(0, 262143)) - 131072;
            end else begin
                ce = 1'b1;
                re = 0;
                im = 0;
            end
            pend_in    = pack(re, im);
            pend_exp   = model(re, im, int'(gain_mem[addr]), 3);
            requant_in = pend_in;
            last_ce    = ce;
            prev_addr  = addr;
            @(negedge clk);
        end
        ce = 1'b1;
        checkOutput("rand_cnt", ovf_count, exp_cnt);

        // Long saturating run: counter pins at 0xFFFF, then reset mid-spectrum.
        for (int k = 0; k < N_CHAN; k++) gain_mem[k] = 11'd2047;
        shift = 4'd0;
        applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, '0);
        sync_in = 1'b0;
        m = model(131071, 131071, 2047, 0);
        requant_in = pack(131071, 131071);
        repeat (65540) @(negedge clk);
        waited = 0;
        while (addr != 11'd500 && waited < 2100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("find_chan500", addr, 500);
        checkOutput("sat_cnt", ovf_count, 16'hFFFF);
        checkOutput("sat_out", requant_out, m[15:0]);
        checkOutput("sat_ovf", overflow, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_rst_addr", addr, 0);
        checkOutput("mid_rst_out", requant_out, 0);
        checkOutput("mid_rst_sync", sync_out, 0);
        checkOutput("mid_rst_ovf", overflow, 0);
        checkOutput("mid_rst_cnt", ovf_count, 0);
        applyStimulus(1'b0, 1'b1, pack(131071, 131071));
        sync_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checkOutput("idle_addr", addr, 0);
            checkOutput("idle_sync", sync_out, 0);
            checkOutput("idle_out", requant_out, 0);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
